flot_accum_seq: RTL and testbench
=================================

// Module: flot_accum_seq
// PURPOSE
//  Sequences one shared registered 8-bit positive float adder (1-cycle latency) to reduce a stream
//  of NTERMS operands to one sum, e.g. one 3x3 convolution window in a floating-point systolic PE.
//  Operands arrive on a valid/ready stream; the result leaves on a valid/ready stream.
//  Float format: [7] sign (always 0), [6:4] exponent (0 = no hidden bit), [3:0] mantissa.
// PARAMETERS
//  NTERMS  9  operands summed per result; legal range 1..15
//  CNT_W   4  term-counter width; 2**CNT_W > NTERMS
// PORTS
//  clk        in   1  single clock; all state updates on posedge
//  rst_n      in   1  synchronous, active-low reset
//  abort      in   1  synchronous; drops the partial sum and returns to IDLE
//  in_valid   in   1  operand valid
//  in_ready   out  1  operand accepted when in_valid && in_ready at posedge
//  in_data    in   8  operand; bit 7 ignored
//  add_a      out  8  adder operand A = acc (combinational)
//  add_b      out  8  adder operand B = {1'b0, in_data[6:0]} (combinational)
//  add_out    in   8  adder result; reflects operands sampled at the previous posedge
//  out_valid  out  1  sum valid
//  out_ready  in   1  sum consumed when out_valid && out_ready at posedge
//  out_data   out  8  sum = acc; bit 7 always 0
//  out_ovf    out  1  sticky: an exponent wrap occurred during this sum; valid with out_valid
//  busy       out  1  high in every state except IDLE
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE, acc=8'h00, cnt=0, ovf=0, bexp=0.
//   Outputs: in_ready=1, out_valid=0, out_data=8'h00, out_ovf=0, busy=0.
//  FSM states IDLE, ACCUM, WAIT, DONE. "hs" = in_valid && in_ready.
//  - IDLE:  in_ready=1. On hs: acc<={0,in_data[6:0]}, cnt<=1, ovf<=0;
//           next state is DONE if NTERMS==1, else ACCUM.
//  - ACCUM: in_ready=1. The adder samples add_a/add_b at this edge.
//           On hs: bexp<=in_data[6:4], go to WAIT. No hs: stay.
//  - WAIT:  in_ready=0. acc<=add_out; cnt<=cnt+1.
//           ovf<=ovf | (add_out[6:4] < max(acc[6:4], bexp)).
//           If cnt+1==NTERMS go to DONE, else ACCUM.
//  - DONE:  out_valid=1, in_ready=0; out_data/out_ovf held stable.
//           On out_ready: go to IDLE (out_valid drops next cycle).
//  Throughput and latency:
//   - Terms 2..N take 2 cycles each.
//   - With in_valid held high, out_valid rises 2*NTERMS-2 cycles after the first-term edge
//     (same edge for NTERMS=1).
//  Exponent overflow: no saturation. The wrapped adder result is stored as-is; only out_ovf flags it.
//  add_a/add_b are driven every cycle. add_out is used only in WAIT.
//  abort: highest priority after reset. At the next posedge: state=IDLE, acc=0, cnt=0, ovf=0.
//   - If asserted in DONE, the pending sum is discarded.
//   - If asserted with hs in IDLE, the operand is dropped.
//  Reset or abort mid-sum: the partial sum is never emitted. out_valid is 0 the cycle after.
//  in_data changes while in_ready=0 are ignored.
// TESTING
//  1 NTERMS=2; send 8'h30, 8'h30 -> out_data=8'h40, out_ovf=0; out_valid exactly 2 cycles
//    after the first-term edge.
//  2 NTERMS=4; four 8'h30 -> partials 8'h40, 8'h48, then out_data=8'h50;
//    busy high from first hs until the out handshake.
//  3 NTERMS=2; 8'h70 + 8'h70 -> out_data=8'h00, out_ovf=1. Next sum 8'h30+8'h30 -> out_ovf=0.
//  4 NTERMS=9; nine 8'h00, out_ready=0 for 5 cycles -> out_valid rises 16 cycles after first hs
//    and holds 8'h00; in_ready=0 until release; IDLE the cycle after out_ready.
//  5 abort after 3 of 9 terms -> IDLE, no out_valid. A following full sum of nine 8'h00
//    gives 8'h00 with out_ovf=0.
//  6 rst_n=0 for 1 cycle while in WAIT -> all outputs at reset values next cycle;
//    random in_valid gaps on a 9-term sum do not change the result.

Source files
------------

// File: rtl/flot_accum_seq.sv
// rtl/flot_accum_seq.sv - sequencer reducing NTERMS positive 8-bit floats to one sum through a shared registered adder
// One operand is accepted per ACCUM visit; the adder result comes back one cycle later in WAIT.
module flot_accum_seq #(
    parameter int NTERMS = 9,
    parameter int CNT_W  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       abort,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic [7:0] add_a,
    output logic [7:0] add_b,
    input  logic [7:0] add_out,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_ovf,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_q;
    logic [7:0]       acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             ovf_q;
    logic [2:0]       bexp_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;

    logic             hs;
    logic             last_term;
    logic [2:0]       max_e;
    logic             wrap;
    logic             unused_bits;

    assign hs        = in_valid && in_ready_q;
    assign cnt_d     = cnt_q + CNT_W'(1);
    assign last_term = (cnt_d == CNT_W'(NTERMS));
    assign max_e     = (acc_q[6:4] > bexp_q) ? acc_q[6:4] : bexp_q;
    // A positive sum can never have a smaller exponent than its larger operand; a drop means it wrapped.
    assign wrap      = (add_out[6:4] < max_e);
    assign unused_bits = &{1'b0, in_data[7], add_out[7]};

    assign add_a     = acc_q;
    assign add_b     = {1'b0, in_data[6:0]};
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = acc_q;
    assign out_ovf   = ovf_q;
    assign busy      = busy_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= 8'h00;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            bexp_q      <= 3'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else if (abort) begin
            state_q     <= IDLE;
            acc_q       <= 8'h00;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hs) begin
                        acc_q  <= {1'b0, in_data[6:0]};
                        cnt_q  <= CNT_W'(1);
                        ovf_q  <= 1'b0;
                        busy_q <= 1'b1;
                        if (NTERMS == 1) begin
                            state_q     <= DONE;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (hs) begin
                        bexp_q     <= in_data[6:4];
                        state_q    <= WAIT;
                        in_ready_q <= 1'b0;
                    end
                end
                WAIT: begin
                    acc_q <= {1'b0, add_out[6:0]};
                    cnt_q <= cnt_d;
                    ovf_q <= ovf_q | wrap;
                    if (last_term) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        state_q    <= ACCUM;
                        in_ready_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flot_accum_seq.sv
// tb/tb_flot_accum_seq.sv - self-checking bench for flot_accum_seq with NTERMS 2, 4 and 9 instances
// Instances share stimulus; s selects the one under test and each has its own registered adder model.
module tb_flot_accum_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       abort;
    logic       in_valid;
    logic       out_ready;
    logic [7:0] in_data;
    logic       in_ready  [3];
    logic       out_valid [3];
    logic       out_ovf   [3];
    logic       busy      [3];
    logic [7:0] add_a     [3];
    logic [7:0] add_b     [3];
    logic [7:0] add_out   [3];
    logic [7:0] out_data  [3];

    int cyc    = 0;
    int checks = 0;
    int errors = 0;
    int s      = 0;

    typedef struct packed {
        logic [7:0] data;
        logic       ovf;
    } exp_t;
    exp_t sb[$];

    flot_accum_seq #(.NTERMS(2), .CNT_W(4)) u_n2 (
        .clk(clk), .rst_n(rst_n), .abort(abort), .in_valid(in_valid), .in_ready(in_ready[0]),
        .in_data(in_data), .add_a(add_a[0]), .add_b(add_b[0]), .add_out(add_out[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready), .out_data(out_data[0]),
        .out_ovf(out_ovf[0]), .busy(busy[0])
    );
    flot_accum_seq #(.NTERMS(4), .CNT_W(4)) u_n4 (
        .clk(clk), .rst_n(rst_n), .abort(abort), .in_valid(in_valid), .in_ready(in_ready[1]),
        .in_data(in_data), .add_a(add_a[1]), .add_b(add_b[1]), .add_out(add_out[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready), .out_data(out_data[1]),
        .out_ovf(out_ovf[1]), .busy(busy[1])
    );
    flot_accum_seq #(.NTERMS(9), .CNT_W(4)) u_n9 (
        .clk(clk), .rst_n(rst_n), .abort(abort), .in_valid(in_valid), .in_ready(in_ready[2]),
        .in_data(in_data), .add_a(add_a[2]), .add_b(add_b[2]), .add_out(add_out[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready), .out_data(out_data[2]),
        .out_ovf(out_ovf[2]), .busy(busy[2])
    );

    function automatic int unsigned fval(input logic [7:0] x);
        if (x[6:4] == 3'd0) return 32'(x[3:0]);
        return (32'd16 + 32'(x[3:0])) << (32'(x[6:4]) - 32'd1);
    endfunction

    // Truncating adder; exponent 8 wraps to 0.
    function automatic logic [7:0] fadd(input logic [7:0] a, input logic [7:0] b);
        int unsigned sum;
        int unsigned e;
        sum = fval(a) + fval(b);
        e   = 1;
        if (sum < 16) return {4'b0000, sum[3:0]};
        while (sum >= 32) begin
            sum = sum >> 1;
            e   = e + 1;
        end
        return {1'b0, e[2:0], sum[3:0]};
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 3; i++) add_out[i] <= fadd(add_a[i], add_b[i]);
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk1({tag, "_in_ready"}, in_ready[s], 1'b1);
        chk1({tag, "_out_valid"}, out_valid[s], 1'b0);
        chk8({tag, "_out_data"}, out_data[s], 8'h00);
        chk1({tag, "_out_ovf"}, out_ovf[s], 1'b0);
        chk1({tag, "_busy"}, busy[s], 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic push(input logic [7:0] d, input logic o);
        exp_t e;
        e.data = d;
        e.ovf  = o;
        sb.push_back(e);
    endtask

    // Returns at the negedge right after the accepting posedge.
    task automatic send(input logic [7:0] d);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        n = 0;
        while (in_ready[s] !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk1("send_ready", in_ready[s], 1'b1);
        tick();
        in_valid = 1'b0;
        in_data  = 8'($urandom_range(0, 255));
    endtask

    task automatic recv(input string tag, input int hold, output int seen);
        int   n;
        exp_t e;
        e = '0;
        n = 0;
        while (out_valid[s] !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk1({tag, "_out_valid"}, out_valid[s], 1'b1);
        seen = cyc;
        chki({tag, "_sb_size"}, sb.size(), 1);
        if (sb.size() > 0) e = sb.pop_front();
        for (int i = 0; i < hold; i++) begin
            chk8({tag, "_hold_data"}, out_data[s], e.data);
            chk1({tag, "_hold_in_ready"}, in_ready[s], 1'b0);
            chk1({tag, "_hold_busy"}, busy[s], 1'b1);
            chk1({tag, "_hold_valid"}, out_valid[s], 1'b1);
            tick();
        end
        chk8({tag, "_out_data"}, out_data[s], e.data);
        chk1({tag, "_out_ovf"}, out_ovf[s], e.ovf);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk1({tag, "_idle_valid"}, out_valid[s], 1'b0);
        chk1({tag, "_idle_busy"}, busy[s], 1'b0);
        chk1({tag, "_idle_in_ready"}, in_ready[s], 1'b1);
    endtask

    initial begin
        int         t0;
        int         seen;
        logic       any_valid;
        logic [7:0] ops [9];
        logic [7:0] acc;
        logic [7:0] bop;
        logic [7:0] r;
        logic [2:0] me;
        logic       ov;

        in_data = 8'h00;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            s = i;
            chk_reset_outputs("reset");
        end

        // 1: NTERMS=2, latency of two cycles
        s = 0;
        do_reset();
        push(8'h40, 1'b0);
        send(8'h30);
        t0 = cyc;
        send(8'h30);
        recv("t1", 0, seen);
        chki("t1_latency", seen - t0, 2);

        // 2: NTERMS=4, partial sums and busy
        s = 1;
        do_reset();
        chk1("t2_busy_before", busy[s], 1'b0);
        push(8'h50, 1'b0);
        send(8'h30);
        chk1("t2_busy_first", busy[s], 1'b1);
        send(8'h30);
        tick();
        chk8("t2_partial1", out_data[s], 8'h40);
        send(8'h30);
        tick();
        chk8("t2_partial2", out_data[s], 8'h48);
        send(8'h30);
        recv("t2", 2, seen);

        // 3: exponent wrap, then a clean sum clears the flag
        s = 0;
        do_reset();
        push(8'h00, 1'b1);
        send(8'h70);
        send(8'h70);
        recv("t3a", 0, seen);
        push(8'h40, 1'b0);
        send(8'h30);
        send(8'h30);
        recv("t3b", 0, seen);

        // 4: NTERMS=9 back-to-back, out_ready held off
        s = 2;
        do_reset();
        push(8'h00, 1'b0);
        send(8'h00);
        t0 = cyc;
        for (int k = 1; k < 9; k++) send(8'h00);
        recv("t4", 5, seen);
        chki("t4_latency", seen - t0, 16);

        // 5: abort mid-sum, abort with a handshake in IDLE, then a full sum
        s = 2;
        do_reset();
        for (int k = 0; k < 3; k++) send(8'h30);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_reset_outputs("t5_abort");
        any_valid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            any_valid = any_valid | out_valid[s];
        end
        chk1("t5_no_valid", any_valid, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'h30;
        abort    = 1'b1;
        tick();
        abort    = 1'b0;
        in_valid = 1'b0;
        chk_reset_outputs("t5_abort_hs");
        push(8'h00, 1'b0);
        for (int k = 0; k < 9; k++) send(8'h00);
        recv("t5", 0, seen);

        // 5b: abort while the sum is pending in DONE
        s = 0;
        do_reset();
        send(8'h30);
        send(8'h30);
        tick();
        chk1("t5b_valid", out_valid[s], 1'b1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_reset_outputs("t5b_abort_done");

        // 6: reset in WAIT, then random sums with input gaps
        s = 2;
        do_reset();
        send(8'h30);
        send(8'h30);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk_reset_outputs("t6_reset_wait");
        for (int n = 0; n < 3; n++) begin
            for (int k = 0; k < 9; k++) ops[k] = 8'($urandom_range(0, 255));
            acc = {1'b0, ops[0][6:0]};
            ov  = 1'b0;
            for (int k = 1; k < 9; k++) begin
                bop = {1'b0, ops[k][6:0]};
                r   = fadd(acc, bop);
                me  = (acc[6:4] > bop[6:4]) ? acc[6:4] : bop[6:4];
                if (r[6:4] < me) ov = 1'b1;
                acc = {1'b0, r[6:0]};
            end
            push(acc, ov);
            for (int k = 0; k < 9; k++) begin
                repeat ($urandom_range(0, 3)) tick();
                send(ops[k]);
            end
            recv("t6", 1, seen);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
